lsu_rmw: RTL and testbench
==========================

// Module: lsu_rmw
// PURPOSE
//  - Load/store unit between the cpu memory stage and the word-wide synchronous data RAM.
//  - Accepts one RV32I load or store per request (funct3 encoding), extracts and extends
//    LB/LH/LW/LBU/LHU results, and performs read-modify-write for SB/SH, since the RAM
//    only writes full words.
//  - Single outstanding request; valid/ready request side, one-cycle response pulse.
// PARAMETERS
//  ADDR_W   7  word-address width driven to RAM (byte address bits [ADDR_W+1:2])
//  MEM_LAT  1  RAM read latency in cycles (address edge -> mem_rdata valid), >=1
// PORTS
//  clk        in   1       clock
//  rst        in   1       reset, synchronous, active-high
//  req_valid  in   1       request present
//  req_ready  out  1       unit idle, request accepted when valid&ready at clk edge
//  req_store  in   1       1=store, 0=load
//  req_op     in   3       funct3: LB0 LH1 LW2 LBU4 LHU5 / SB0 SH1 SW2
//  req_addr   in   32      byte address
//  req_wdata  in   32      store data (low byte/half used for SB/SH)
//  resp_valid out  1       one-cycle completion pulse
//  resp_data  out  32      load result (0 for stores and errors)
//  resp_err   out  1       request rejected (bad op / misaligned), no RAM write
//  mem_addr   out  ADDR_W  RAM word address
//  mem_wren   out  1       RAM write enable
//  mem_wdata  out  32      RAM write data
//  mem_rdata  in   32      RAM read data
// BEHAVIOUR
//  - Reset (rst high at edge): state IDLE; resp_valid/resp_err/mem_wren=0; resp_data,
//    mem_addr, mem_wdata=0; req_ready=0 while rst high. Reset mid-op abandons the op:
//    no write, no response.
//  - States: IDLE, RD (MEM_LAT cycles), WR (1 cycle), RESP (1 cycle), then back to IDLE.
//  - req_ready=1 only in IDLE. req_valid while busy is ignored, never queued.
//    Request fields are latched at acceptance.
//  - Load: IDLE->RD->RESP. resp_valid goes high MEM_LAT+1 cycles after the accept edge.
//    Lane=addr[1:0]. LB/LBU take rdata[8*lane+:8]; LH/LHU take rdata[16*addr[1]+:16].
//    LB/LH sign-extend; LBU/LHU zero-extend. LW returns the full word.
//  - SW: IDLE->WR->RESP. mem_wren=1 for exactly one cycle with mem_wdata=req_wdata.
//  - SB/SH: IDLE->RD->WR->RESP. WR writes the read word with the target lane replaced.
//    resp_valid goes high MEM_LAT+2 cycles after accept.
//  - mem_addr=addr[ADDR_W+1:2], held from accept through WR. Upper address bits are
//    ignored, so addresses wrap modulo 2^(ADDR_W+2).
//  - Invalid op (load funct3 3/6/7, store funct3>=3): IDLE->RESP with resp_err=1, no RAM
//    access.
//  - resp_data/resp_err are valid only while resp_valid=1 and are cleared to 0 otherwise.
//    mem_wren is asserted only in WR.
// CONFIGURATION
//  LSU_MISALIGN_TRAP_EN defined: LH/LHU/SH with addr[0]!=0, or LW/SW with addr[1:0]!=0,
//    go IDLE->RESP with resp_err=1 and no RAM access.
//  Not defined: low address bits below natural alignment are forced to 0 and the access
//    completes normally with resp_err=0.
// TESTING
//  - RAM word 3 = 0x8081_F2F3; LB addr 0x0D -> resp_valid at accept+2 (MEM_LAT=1),
//    resp_data=0xFFFF_FFF2. LBU addr 0x0D -> 0x0000_00F2.
//  - LHU addr 0x0E -> 0x0000_8081; LH addr 0x0E -> 0xFFFF_8081; LW addr 0x0C ->
//    0x8081_F2F3.
//  - SB data 0xAA to addr 0x0D -> one mem_wren pulse, mem_addr=3, mem_wdata=0x8081_AAF3,
//    resp at accept+3. SW 0x1234_5678 to addr 0x10 -> mem_wdata=0x1234_5678, resp at
//    accept+2.
//  - Store op 3 -> resp_err=1 at accept+1, mem_wren never asserted. LW addr 0x0E ->
//    resp_err=1 with the macro defined; without it, reads word 3 with resp_err=0.
//  - rst asserted in the cycle after SB accept -> no mem_wren and no resp_valid.
//    req_ready=1 after rst releases. A req_valid held during a busy op is accepted only
//    after RESP.
//  - Address 0x200+0x0C with ADDR_W=7 -> mem_addr=3 (wrap).

Source files
------------

// File: rtl/lsu_rmw_if.sv
// lsu_rmw_if: cpu request/response and word-RAM signals of the load/store unit
interface lsu_rmw_if #(parameter int ADDR_W = 7);
    logic              req_valid;
    logic              req_ready;
    logic              req_store;
    logic [2:0]        req_op;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_data;
    logic              resp_err;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wren;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    modport master (
        output req_valid, req_store, req_op, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_data, resp_err, mem_addr, mem_wren, mem_wdata
    );
    modport slave (
        input  req_valid, req_store, req_op, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_data, resp_err, mem_addr, mem_wren, mem_wdata
    );
endinterface

// File: rtl/lsu_rmw.sv
// lsu_rmw: RV32I load/store unit with byte/half read-modify-write on a word RAM (LSU_MISALIGN_TRAP_EN traps misaligned accesses)
module lsu_rmw #(
    parameter int ADDR_W  = 7,
    parameter int MEM_LAT = 1
) (
    input logic       clk,
    input logic       rst,
    lsu_rmw_if.slave  bus
);
    localparam int CW = $clog2(MEM_LAT + 1);
    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;
    state_t            r_state, w_next;
    logic [CW-1:0]     r_cnt;
    logic              r_store, r_err;
    logic [2:0]        r_op;
    logic [1:0]        r_lane;
    logic [31:0]       r_wdata, r_data, r_word;
    logic [ADDR_W-1:0] r_addr;
    logic              w_accept, w_bad, w_mis, w_err, w_rd_done;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_load, w_merge;
    assign w_accept  = bus.req_valid && bus.req_ready;
    assign w_bad     = bus.req_store ? bus.req_op > 3'd2 : (bus.req_op == 3'd3 || bus.req_op > 3'd5);
`ifdef LSU_MISALIGN_TRAP_EN
    assign w_mis     = (bus.req_op[1:0] == 2'd1 && bus.req_addr[0]) ||
                       (bus.req_op[1:0] == 2'd2 && bus.req_addr[1:0] != 2'd0);
`else
    assign w_mis     = 1'b0;
`endif
    assign w_err     = w_bad || w_mis;
    assign w_rd_done = r_cnt == CW'(MEM_LAT - 1);
    // lanes below natural alignment are ignored, which realigns when traps are off
    assign w_byte    = bus.mem_rdata[{r_lane, 3'b000} +: 8];
    assign w_half    = bus.mem_rdata[{r_lane[1], 4'b0000} +: 16];
    assign w_load    = r_op[1:0] == 2'd0 ? {{24{~r_op[2] & w_byte[7]}}, w_byte} :
                       r_op[1:0] == 2'd1 ? {{16{~r_op[2] & w_half[15]}}, w_half} : bus.mem_rdata;
    always_comb begin
        w_merge = r_word;
        if (r_op[1:0] == 2'd0)
            w_merge[{r_lane, 3'b000} +: 8] = r_wdata[7:0];
        else if (r_op[1:0] == 2'd1)
            w_merge[{r_lane[1], 4'b0000} +: 16] = r_wdata[15:0];
        else
            w_merge = r_wdata;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.req_valid) w_next = w_err ? RESP : (bus.req_store && bus.req_op == 3'd2) ? WR : RD;
            RD:      if (w_rd_done) w_next = r_store ? WR : RESP;
            WR:      w_next = RESP;
            default: w_next = IDLE;
        endcase
    end
    assign bus.req_ready  = r_state == IDLE && !rst;
    assign bus.resp_valid = r_state == RESP && !rst;
    assign bus.resp_data  = bus.resp_valid ? r_data : 32'd0;
    assign bus.resp_err   = bus.resp_valid && r_err;
    assign bus.mem_wren   = r_state == WR && !rst;
    assign bus.mem_wdata  = bus.mem_wren ? w_merge : 32'd0;
    assign bus.mem_addr   = rst ? '0 : w_accept ? bus.req_addr[ADDR_W+1:2] : r_addr;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_store <= 1'b0;
            r_err   <= 1'b0;
            r_op    <= 3'd0;
            r_lane  <= 2'd0;
            r_wdata <= 32'd0;
            r_data  <= 32'd0;
            r_word  <= 32'd0;
            r_addr  <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (r_state == RD && !w_rd_done) ? r_cnt + 1'b1 : '0;
            if (w_accept) begin
                r_store <= bus.req_store;
                r_err   <= w_err;
                r_op    <= bus.req_op;
                r_lane  <= bus.req_addr[1:0];
                r_wdata <= bus.req_wdata;
                r_data  <= 32'd0;
                r_addr  <= bus.req_addr[ADDR_W+1:2];
            end
            if (r_state == RD && w_rd_done) begin
                r_word <= bus.mem_rdata;
                if (!r_store) r_data <= w_load;
            end
        end
    end
endmodule

// File: tb/tb_lsu_rmw.sv
// tb_lsu_rmw: directed vectors against a byte-lane memory model of the load/store unit
module tb_lsu_rmw;
    localparam int ADDR_W = 7;
    localparam bit TRAP =
`ifdef LSU_MISALIGN_TRAP_EN
        1'b1;
`else
        1'b0;
`endif
    typedef struct {
        bit          st;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] pin;
        int          lat;
        bit          err;
    } vec_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    logic [31:0] ram [128];
    logic [31:0] mdl [128];
    int          exp_a = -1, exp_r = -1, exp_w = -1;
    bit          exp_err = 1'b0;
    logic [31:0] exp_rd = 32'd0, exp_wd = 32'd0;
    logic [ADDR_W-1:0] exp_wa = '0;
    vec_t vecs [$];
    lsu_rmw_if #(.ADDR_W(ADDR_W)) bus ();
    lsu_rmw #(.ADDR_W(ADDR_W), .MEM_LAT(1)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    function automatic logic [31:0] init_word(input int i);
        return (i == 3) ? 32'h8081_F2F3 : 32'(i) * 32'h0101_0101;
    endfunction
    // synchronous RAM, one cycle read latency
    always @(posedge clk) begin
        if (cyc == 0) begin
            for (int i = 0; i < 128; i++) ram[i] <= init_word(i);
        end else begin
            if (bus.mem_wren) ram[bus.mem_addr] <= bus.mem_wdata;
            bus.mem_rdata <= ram[bus.mem_addr];
        end
    end
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, req, cyc);
        end
    endtask
    function automatic vec_t mk(input bit st, input logic [2:0] op, input logic [31:0] addr,
                                input logic [31:0] wd, input logic [31:0] pin, input int lat, input bit err);
        vec_t v;
        v.st = st; v.op = op; v.addr = addr; v.wd = wd; v.pin = pin; v.lat = lat; v.err = err;
        return v;
    endfunction
    function automatic void model(input vec_t v, output int lat, output bit err, output logic [31:0] val,
                                  output logic [ADDR_W-1:0] wa, output bit wr);
        int ba, sz, lna;
        logic [31:0] word, mask;
        ba   = int'(v.addr % 32'd512);
        wa   = ADDR_W'(ba / 4);
        word = mdl[ba / 4];
        sz   = (v.op[1:0] == 2'd0) ? 1 : (v.op[1:0] == 2'd1) ? 2 : 4;
        err  = v.st ? (v.op > 3'd2) : (v.op == 3'd3 || v.op > 3'd5);
        if (TRAP && (ba % sz) != 0) err = 1'b1;
        lna  = (ba % 4) / sz * sz;
        mask = (sz == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * sz)) - 32'd1;
        wr = 1'b0; val = 32'd0; lat = 1;
        if (err) return;
        if (v.st) begin
            wr  = 1'b1;
            lat = (sz == 4) ? 2 : 3;
            val = (word & ~(mask << (8 * lna))) | ((v.wd & mask) << (8 * lna));
        end else begin
            lat = 2;
            val = (word >> (8 * lna)) & mask;
            if (!v.op[2] && sz < 4 && val[8 * sz - 1]) val = val | ~mask;
        end
    endfunction
    task automatic issue(input vec_t v, input bit hold);
        int k, lat;
        bit err, wr;
        logic [31:0] val;
        logic [ADDR_W-1:0] wa;
        bus.req_store = v.st; bus.req_op = v.op; bus.req_addr = v.addr; bus.req_wdata = v.wd;
        bus.req_valid = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.req_ready && k < 40);
        if (!bus.req_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        model(v, lat, err, val, wa, wr);
        chk("pin_lat", 32'(lat), 32'(v.lat));
        chk("pin_err", 32'(err), 32'(v.err));
        chk("pin_val", val, v.pin);
        exp_a   = cyc;
        exp_r   = cyc + lat - 1;
        exp_w   = wr ? exp_r - 1 : -1;
        exp_err = err;
        exp_wa  = wa;
        exp_wd  = val;
        exp_rd  = (wr || err) ? 32'd0 : val;
        if (!hold) bus.req_valid = 1'b0;
    endtask
    always @(negedge clk) begin
        bit rv, wv, busy;
        if (cyc <= 1) for (int i = 0; i < 128; i++) mdl[i] = init_word(i);
        rv   = (cyc == exp_r);
        wv   = (cyc == exp_w);
        busy = (cyc >= exp_a && cyc <= exp_r);
        chk("req_ready", 32'(bus.req_ready), 32'(!rst && !busy));
        chk("resp_valid", 32'(bus.resp_valid), 32'(rv));
        chk("resp_data", bus.resp_data, rv ? exp_rd : 32'd0);
        chk("resp_err", 32'(bus.resp_err), 32'(rv && exp_err));
        chk("mem_wren", 32'(bus.mem_wren), 32'(wv));
        if (wv) begin
            chk("mem_wdata", bus.mem_wdata, exp_wd);
            mdl[exp_wa] = exp_wd;
        end
        if (busy && !exp_err && cyc < exp_r) chk("mem_addr", 32'(bus.mem_addr), 32'(exp_wa));
        if (rst) begin
            chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
            chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        end
    end
    initial begin
        int r1;
        bus.req_valid = 1'b0; bus.req_store = 1'b0; bus.req_op = 3'd0;
        bus.req_addr = 32'd0; bus.req_wdata = 32'd0;
        vecs.push_back(mk(0, 3'd0, 32'h0D, 0, 32'hFFFF_FFF2, 2, 0));
        vecs.push_back(mk(0, 3'd4, 32'h0D, 0, 32'h0000_00F2, 2, 0));
        vecs.push_back(mk(0, 3'd5, 32'h0E, 0, 32'h0000_8081, 2, 0));
        vecs.push_back(mk(0, 3'd1, 32'h0E, 0, 32'hFFFF_8081, 2, 0));
        vecs.push_back(mk(0, 3'd2, 32'h0C, 0, 32'h8081_F2F3, 2, 0));
        vecs.push_back(mk(0, 3'd0, 32'h0F, 0, 32'hFFFF_FF80, 2, 0));
        vecs.push_back(mk(0, 3'd1, 32'h0C, 0, 32'hFFFF_F2F3, 2, 0));
        vecs.push_back(mk(1, 3'd0, 32'h0D, 32'h0000_00AA, 32'h8081_AAF3, 3, 0));
        vecs.push_back(mk(0, 3'd2, 32'h0C, 0, 32'h8081_AAF3, 2, 0));
        vecs.push_back(mk(1, 3'd2, 32'h10, 32'h1234_5678, 32'h1234_5678, 2, 0));
        vecs.push_back(mk(0, 3'd2, 32'h10, 0, 32'h1234_5678, 2, 0));
        vecs.push_back(mk(1, 3'd1, 32'h12, 32'hFFFF_BEEF, 32'hBEEF_5678, 3, 0));
        vecs.push_back(mk(0, 3'd1, 32'h12, 0, 32'hFFFF_BEEF, 2, 0));
        vecs.push_back(mk(1, 3'd0, 32'h13, 32'h0000_0155, 32'h55EF_5678, 3, 0));
        vecs.push_back(mk(0, 3'd2, 32'h10, 0, 32'h55EF_5678, 2, 0));
        vecs.push_back(mk(1, 3'd3, 32'h0C, 32'hDEAD_BEEF, 32'd0, 1, 1));
        vecs.push_back(mk(0, 3'd3, 32'h0C, 0, 32'd0, 1, 1));
        vecs.push_back(mk(0, 3'd6, 32'h0C, 0, 32'd0, 1, 1));
        vecs.push_back(mk(0, 3'd7, 32'h0C, 0, 32'd0, 1, 1));
        vecs.push_back(mk(0, 3'd2, 32'h20C, 0, 32'h8081_AAF3, 2, 0));
        vecs.push_back(mk(1, 3'd0, 32'h20C, 32'h0000_0011, 32'h8081_AA11, 3, 0));
        vecs.push_back(mk(0, 3'd5, 32'h3FE, 0, 32'h0000_7F7F, 2, 0));
        vecs.push_back(mk(0, 3'd2, 32'h0E, 0, TRAP ? 32'd0 : 32'h8081_AA11, TRAP ? 1 : 2, TRAP));
        vecs.push_back(mk(0, 3'd1, 32'h0D, 0, TRAP ? 32'd0 : 32'hFFFF_AA11, TRAP ? 1 : 2, TRAP));
        vecs.push_back(mk(1, 3'd1, 32'h11, 32'h0000_7777, TRAP ? 32'd0 : 32'h55EF_7777, TRAP ? 1 : 3, TRAP));
        vecs.push_back(mk(1, 3'd2, 32'h13, 32'hCAFE_F00D, TRAP ? 32'd0 : 32'hCAFE_F00D, TRAP ? 1 : 2, TRAP));
        vecs.push_back(mk(0, 3'd2, 32'h10, 0, TRAP ? 32'h55EF_5678 : 32'hCAFE_F00D, 2, 0));
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        foreach (vecs[i]) issue(vecs[i], 1'b0);
        // reset one cycle after an SB accept must drop the write and the response
        issue(mk(1, 3'd0, 32'h0D, 32'h0000_0099, 32'h8081_9911, 3, 0), 1'b0);
        rst = 1'b1;
        exp_a = -1; exp_r = -1; exp_w = -1;
        @(posedge clk);
        #1 rst = 1'b0;
        issue(mk(0, 3'd2, 32'h0C, 0, 32'h8081_AA11, 2, 0), 1'b0);
        // a request held high while busy is taken on the first idle cycle after RESP
        issue(mk(0, 3'd2, 32'h0C, 0, 32'h8081_AA11, 2, 0), 1'b1);
        r1 = exp_r;
        issue(mk(0, 3'd4, 32'h0F, 0, 32'h0000_0080, 2, 0), 1'b0);
        chk("held_accept_cycle", 32'(exp_a), 32'(r1 + 2));
        repeat (5) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
